// File: rtl/atm_seg_scan.sv
// Eight-digit multiplexed 7-segment scanner. Input content is captured once per frame.
// It supports leading-zero blanking and blinking of the digit being edited.
module atm_seg_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [2:0]  sel_i,
  input  logic        blink_en,
  input  logic        lz_en,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int PC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PC_W-1:0] PC_ZERO  = {PC_W{1'b0}};
  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);
  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(SCAN_DIV - 1);
  localparam logic [PC_W-1:0] PC_BLANK = PC_W'(BLANK_CYC);
  localparam logic [FC_W-1:0] FC_ZERO  = {FC_W{1'b0}};
  localparam logic [FC_W-1:0] FC_ONE   = FC_W'(1);
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_nxt_s;
  logic [2:0]      idx_r;
  logic [2:0]      idx_nxt_s;
  logic [FC_W-1:0] fc_r;
  logic [FC_W-1:0] fc_nxt_s;
  logic            bp_r;
  logic            bp_nxt_s;

  logic [31:0]     data_r;
  logic [2:0]      sel_r;
  logic            blink_r;
  logic            lz_r;

  logic            pc_wrap_s;
  logic            frame_end_s;
  logic            capture_s;
  logic [7:0]      lz_mask_s;
  logic [3:0]      cur_dig_s;
  logic            blank_s;
  logic [7:0]      an_nxt_s;
  logic [6:0]      seg_nxt_s;
  logic [7:0]      an_r;
  logic [6:0]      seg_r;
  logic            dp_r;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Bit k is set when digits k..7 are all zero; digit 0 is never a leading zero.
  function automatic logic [7:0] lz_mask(input logic [31:0] d);
    logic [7:0] m;
    logic       zero_above;
    m          = 8'h00;
    zero_above = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      zero_above = zero_above & (d[4*k +: 4] == 4'h0);
      m[k]       = zero_above;
    end
    return m;
  endfunction

  assign pc_wrap_s   = (pc_r == PC_LAST);
  assign frame_end_s = pc_wrap_s && (idx_r == 3'd7);
  assign capture_s   = (pc_r == PC_ZERO) && (idx_r == 3'd0);

  // Scan position and blink phase sequencing.
  always_comb begin
    pc_nxt_s  = pc_r;
    idx_nxt_s = idx_r;
    fc_nxt_s  = fc_r;
    bp_nxt_s  = bp_r;
    if (pc_wrap_s) begin
      pc_nxt_s  = PC_ZERO;
      idx_nxt_s = idx_r + 3'd1;
    end else begin
      pc_nxt_s  = pc_r + PC_ONE;
    end
    if (frame_end_s) begin
      if (fc_r == FC_LAST) begin
        fc_nxt_s = FC_ZERO;
        bp_nxt_s = ~bp_r;
      end else begin
        fc_nxt_s = fc_r + FC_ONE;
      end
    end else begin
      fc_nxt_s = fc_r;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r  <= PC_ZERO;
      idx_r <= 3'd0;
      fc_r  <= FC_ZERO;
      bp_r  <= 1'b0;
    end else begin
      pc_r  <= pc_nxt_s;
      idx_r <= idx_nxt_s;
      fc_r  <= fc_nxt_s;
      bp_r  <= bp_nxt_s;
    end
  end

  // Frame registers change only at the start of slot 0, so a frame never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r  <= 32'h0000_0000;
      sel_r   <= 3'd0;
      blink_r <= 1'b0;
      lz_r    <= 1'b0;
    end else if (capture_s) begin
      data_r  <= data_i;
      sel_r   <= sel_i;
      blink_r <= blink_en;
      lz_r    <= lz_en;
    end else begin
      data_r  <= data_r;
      sel_r   <= sel_r;
      blink_r <= blink_r;
      lz_r    <= lz_r;
    end
  end

  assign lz_mask_s = lz_mask(data_r);
  assign cur_dig_s = data_r[{idx_r, 2'b00} +: 4];
  assign blank_s   = (blink_r && bp_r && (idx_r == sel_r)) || (lz_r && lz_mask_s[idx_r]);

  // Next anode/cathode pattern; segments are dark during the guard interval as well.
  always_comb begin
    an_nxt_s  = 8'hFF;
    seg_nxt_s = 7'h7F;
    if (pc_r < PC_BLANK) begin
      an_nxt_s  = 8'hFF;
      seg_nxt_s = 7'h7F;
    end else begin
      an_nxt_s  = ~(8'h01 << idx_r);
      if (blank_s) begin
        seg_nxt_s = 7'h7F;
      end else begin
        seg_nxt_s = seg_decode(cur_dig_s);
      end
    end
  end

  // Output registers; the async clear darkens the display in the cycle reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_r  <= 8'hFF;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
      dp_r  <= 1'b1;
    end
  end

  assign an_o  = an_r;
  assign seg_o = seg_r;
  assign dp_o  = dp_r;

endmodule

// File: tb/tb_atm_seg_scan.sv
// Self-checking bench for atm_seg_scan. It uses a small cycle model and per-vector
// expected segment tables. A scoreboard queue pairs each cycle's expectation with the DUT output.
module tb_atm_seg_scan;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_i;
  logic [2:0]  sel_i;
  logic        blink_en;
  logic        lz_en;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  atm_seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .sel_i(sel_i), .blink_en(blink_en),
    .lz_en(lz_en), .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     data;
    logic [2:0]      sel;
    logic            blink;
    logic            lz;
    logic [7:0][6:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    bit         chk_seg;
    int         idx;
  } exp_t;

  vec_t            vt [10];
  exp_t            sbq [$];
  int              n_vec = 0;
  int              n_bad = 0;
  int              pc_m, idx_m, fc_m;
  bit              bp_m;
  logic [7:0][6:0] cur_exp, cap_exp;
  logic            cap_blink;
  logic [2:0]      cap_sel;
  logic [6:0]      obs_seg [8];
  logic [6:0]      bexp [6];

  function automatic vec_t mk(input logic [31:0] d, input logic [2:0] s, input logic b,
                              input logic l, input logic [55:0] e);
    vec_t v;
    v.data = d; v.sel = s; v.blink = b; v.lz = l; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, got, want);
    end
  endtask

  task automatic apply(input int i);
    data_i   = vt[i].data;
    sel_i    = vt[i].sel;
    blink_en = vt[i].blink;
    lz_en    = vt[i].lz;
    cur_exp  = vt[i].exp;
  endtask

  task automatic model_reset();
    pc_m = 0; idx_m = 0; fc_m = 0; bp_m = 1'b0;
    cap_exp = {8{7'h40}};
    cap_blink = 1'b0;
    cap_sel = 3'd0;
    sbq.delete();
  endtask

  task automatic step();
    exp_t e;
    e.idx = idx_m;
    if (pc_m < BC) begin
      e.an = 8'hFF; e.seg = 7'h7F; e.chk_seg = 1'b0;
    end else begin
      e.an = ~(8'h01 << idx_m);
      e.chk_seg = 1'b1;
      e.seg = (cap_blink && bp_m && (idx_m == int'(cap_sel))) ? 7'h7F : cap_exp[idx_m];
    end
    sbq.push_back(e);
    @(posedge clk);
    if (pc_m == 0 && idx_m == 0) begin
      cap_exp = cur_exp; cap_blink = blink_en; cap_sel = sel_i;
    end
    if (pc_m == SD - 1) begin
      pc_m = 0;
      if (idx_m == 7) begin
        idx_m = 0;
        if (fc_m == BF - 1) begin fc_m = 0; bp_m = !bp_m; end
        else fc_m++;
      end else begin
        idx_m++;
      end
    end else begin
      pc_m++;
    end
    #1;
    e = sbq.pop_front();
    check("an", an_o, e.an);
    if (e.chk_seg) begin
      check("seg", {1'b0, seg_o}, {1'b0, e.seg});
      obs_seg[e.idx] = seg_o;
    end
    check("dp", {7'b0, dp_o}, 8'h01);
  endtask

  initial begin
    vt[0] = mk(32'h87654321, 3'd0, 1'b0, 1'b0, {7'h00,7'h78,7'h02,7'h12,7'h19,7'h30,7'h24,7'h79});
    vt[1] = mk(32'h00000000, 3'd0, 1'b0, 1'b0, {8{7'h40}});
    vt[2] = mk(32'h00000120, 3'd0, 1'b0, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h24,7'h40});
    vt[3] = mk(32'hFA000000, 3'd0, 1'b0, 1'b0, {7'h3F,7'h3F,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40});
    vt[4] = mk(32'h00000000, 3'd0, 1'b0, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40});
    vt[5] = mk(32'h09000000, 3'd0, 1'b0, 1'b1, {7'h7F,7'h10,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40});
    vt[6] = mk(32'h0000C005, 3'd0, 1'b0, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h3F,7'h40,7'h40,7'h12});
    vt[7] = mk(32'h11111111, 3'd3, 1'b1, 1'b0, {8{7'h79}});
    vt[8] = mk(32'h00F00000, 3'd5, 1'b1, 1'b1, {7'h7F,7'h7F,7'h3F,7'h40,7'h40,7'h40,7'h40,7'h40});
    vt[9] = mk(32'h90000009, 3'd0, 1'b1, 1'b0, {7'h10,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h10});
    bexp = '{7'h79, 7'h79, 7'h7F, 7'h7F, 7'h79, 7'h79};

    // Reset state, then the first frame with a mid-frame data change.
    rst = 1'b0;
    apply(0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_an", an_o, 8'hFF);
    check("rst_seg", {1'b0, seg_o}, 8'h7F);
    check("rst_dp", {7'b0, dp_o}, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int s = 0; s < 128; s++) begin
      if (s == 20) apply(1);
      step();
    end

    // Table vectors, four frames each so both blink phases are exercised.
    for (int i = 2; i < 10; i++) begin
      apply(i);
      repeat (256) step();
    end

    // Blink phase sequence from a fresh reset.
    apply(7);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check("rst2_an", an_o, 8'hFF);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int f = 0; f < 6; f++) begin
      obs_seg[3] = 7'h00;
      obs_seg[2] = 7'h00;
      repeat (64) step();
      check("blink_d3", {1'b0, obs_seg[3]}, {1'b0, bexp[f]});
      check("blink_d2", {1'b0, obs_seg[2]}, 8'h79);
    end

    // Reset asserted mid-slot 5.
    begin : mid_rst
      int guard;
      guard = 0;
      while (!(idx_m == 5 && pc_m == 4) && guard < 200) begin
        step();
        guard++;
      end
      check("slot5_an", an_o, 8'hDF);
      #2 rst = 1'b0;
      #1;
      check("async_an", an_o, 8'hFF);
      check("async_seg", {1'b0, seg_o}, 8'h7F);
      check("async_dp", {7'b0, dp_o}, 8'h01);
      @(posedge clk);
      #1 check("held_an", an_o, 8'hFF);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (24) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
